// File: rtl/div_16q9_pkg.sv
// ============================================================================
// Module  : div_16q9_pkg
// Brief   : Shared widths, saturation limits and FSM encoding for the
//           Q18 / Q9 iterative divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_16q9_pkg;

   localparam int N_W   = 36;
   localparam int D_W   = 16;
   localparam int Q_W   = 16;
   localparam int FRAC  = 9;
   localparam int CNT_W = 6;

   localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
   localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

   localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(N_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/div_16q9_rnd_sat.sv
// ============================================================================
// Module  : div_16q9_rnd_sat
// Brief   : Combinational round-half-away, sign restore, saturation and
//           divide-by-zero override for the divider result.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_16q9_rnd_sat
   import div_16q9_pkg::*;
(
   input  logic [N_W-1:0]        quo_i,
   input  logic [D_W:0]          rem_i,
   input  logic [D_W-1:0]        dmag_i,
   input  logic                  sign_i,
   input  logic                  dz_i,
   input  logic signed [N_W-1:0] n_i,
   output logic signed [Q_W-1:0] q_sat_o,
   output logic signed [N_W-1:0] r_o,
   output logic                  sat_o,
   output logic                  dz_o
);

   localparam logic [N_W:0] C_POS_LIM = 37'd32767;
   localparam logic [N_W:0] C_NEG_LIM = 37'd32768;

   logic           w_rnd_up;
   logic [N_W:0]   w_qr;
   logic [N_W-1:0] w_rmag;

   // 37-bit magnitude so Q + 1 cannot wrap even for |n| = 2^35.
   assign w_rnd_up = {rem_i, 1'b0} >= {2'b00, dmag_i};
   assign w_qr     = {1'b0, quo_i} + {{N_W{1'b0}}, w_rnd_up};
   assign w_rmag   = {{(N_W-D_W-1){1'b0}}, rem_i};

   always_comb begin
      q_sat_o = '0;
      r_o     = n_i[N_W-1] ? -w_rmag : w_rmag;
      sat_o   = 1'b0;
      dz_o    = 1'b0;
      if (dz_i) begin
         q_sat_o = n_i[N_W-1] ? Q_MIN : Q_MAX;
         r_o     = n_i;
         sat_o   = 1'b1;
         dz_o    = 1'b1;
      end else if (sign_i) begin
         if (w_qr > C_NEG_LIM) begin
            q_sat_o = Q_MIN;
            sat_o   = 1'b1;
         end else begin
            q_sat_o = -w_qr[Q_W-1:0];
         end
      end else begin
         if (w_qr > C_POS_LIM) begin
            q_sat_o = Q_MAX;
            sat_o   = 1'b1;
         end else begin
            q_sat_o = w_qr[Q_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/div_16q9_acc36.sv
// ============================================================================
// Module  : div_16q9_acc36
// Brief   : Iterative signed Q18 / Q9 -> Q9 divider, one quotient bit per
//           cycle, with valid/ready handshakes on both sides.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_16q9_acc36
   import div_16q9_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic signed [N_W-1:0] n_i,
   input  logic signed [D_W-1:0] d_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic signed [Q_W-1:0] q_sat_o,
   output logic signed [N_W-1:0] r_o,
   output logic                  sat_o,
   output logic                  dz_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   state_t r_state, w_state_nxt;

   logic [CNT_W-1:0]      r_cnt;
   logic [N_W-1:0]        r_quo;
   logic [D_W:0]          r_rem;
   logic [D_W-1:0]        r_dmag;
   logic                  r_sign;
   logic                  r_dz;
   logic signed [N_W-1:0] r_n;

   logic                  w_accept;
   logic [D_W+1:0]        w_trial;
   logic                  w_ge;
   logic [D_W:0]          w_diff;

   logic signed [Q_W-1:0] w_q_sat;
   logic signed [N_W-1:0] w_r;
   logic                  w_sat;
   logic                  w_dz;

   assign ready_o  = (r_state == IDLE);
   assign valid_o  = (r_state == DONE);
   assign w_accept = valid_i & ready_o;

   // The dividend magnitude shifts out of r_quo MSB-first while quotient bits shift in.
   assign w_trial = {r_rem, r_quo[N_W-1]};
   assign w_ge    = w_trial >= {2'b00, r_dmag};
   assign w_diff  = w_trial[D_W:0] - {1'b0, r_dmag};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)             w_state_nxt = CALC;
         CALC:    if (r_cnt == C_LAST_ITER) w_state_nxt = ROUND;
         ROUND:                             w_state_nxt = DONE;
         DONE:    if (ready_i)              w_state_nxt = IDLE;
         default:                           w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dmag  <= '0;
         r_sign  <= 1'b0;
         r_dz    <= 1'b0;
         r_n     <= '0;
         q_sat_o <= '0;
         r_o     <= '0;
         sat_o   <= 1'b0;
         dz_o    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_state == CALC) ? r_cnt + 1'b1 : '0;
         if (w_accept) begin
            r_sign <= n_i[N_W-1] ^ d_i[D_W-1];
            r_quo  <= n_i[N_W-1] ? -n_i : n_i;
            r_dmag <= d_i[D_W-1] ? -d_i : d_i;
            r_dz   <= (d_i == '0);
            r_n    <= n_i;
            r_rem  <= '0;
         end else if (r_state == CALC) begin
            r_quo <= {r_quo[N_W-2:0], w_ge};
            r_rem <= w_ge ? w_diff : w_trial[D_W:0];
         end
         if (r_state == ROUND) begin
            q_sat_o <= w_q_sat;
            r_o     <= w_r;
            sat_o   <= w_sat;
            dz_o    <= w_dz;
         end
      end
   end

   div_16q9_rnd_sat u_rnd_sat (
      .quo_i   (r_quo),
      .rem_i   (r_rem),
      .dmag_i  (r_dmag),
      .sign_i  (r_sign),
      .dz_i    (r_dz),
      .n_i     (r_n),
      .q_sat_o (w_q_sat),
      .r_o     (w_r),
      .sat_o   (w_sat),
      .dz_o    (w_dz)
   );

endmodule

`default_nettype wire

// File: tb/tb_div_16q9_acc36.sv
// ============================================================================
// Module  : tb_div_16q9_acc36
// Brief   : Self-checking bench for div_16q9_acc36 against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_16q9_acc36;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic signed [35:0] n_i;
   logic signed [15:0] d_i;
   logic               valid_i;
   logic               ready_o;
   logic signed [15:0] q_sat_o;
   logic signed [35:0] r_o;
   logic               sat_o;
   logic               dz_o;
   logic               valid_o;
   logic               ready_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   div_16q9_acc36 dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .n_i     (n_i),
      .d_i     (d_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .q_sat_o (q_sat_o),
      .r_o     (r_o),
      .sat_o   (sat_o),
      .dz_o    (dz_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: round(n/d) half away from zero on raw integers, then clamp.
   task automatic model(input longint n, input longint d,
                        output longint q, output longint r,
                        output longint sat, output longint dz);
      longint an, ad, qt, rt, qr, s;
      if (d == 0) begin
         q = (n < 0) ? -32768 : 32767;
         r = n; sat = 1; dz = 1;
      end else begin
         an = (n < 0) ? -n : n;
         ad = (d < 0) ? -d : d;
         qt = an / ad;
         rt = an % ad;
         qr = qt + ((2 * rt >= ad) ? 1 : 0);
         s  = ((n < 0) != (d < 0)) ? -qr : qr;
         sat = 0; dz = 0;
         if (s > 32767) begin q = 32767; sat = 1; end
         else if (s < -32768) begin q = -32768; sat = 1; end
         else q = s;
         r = (n < 0) ? -rt : rt;
      end
   endtask

   task automatic wait_ready(input string tag);
      int t = 0;
      while (!ready_o && t < 100) begin @(posedge clk_i); #1; t++; end
      chk({tag, "_ready_wait"}, longint'(ready_o), 1);
   endtask

   // One division; optionally stalls DONE for `hold` cycles or pulses valid_i in CALC.
   task automatic div_check(input string tag, input longint n, input longint d,
                            input int hold, input bit pulse);
      longint eq, er, es, ez;
      longint q0;
      int lat;
      model(n, d, eq, er, es, ez);
      wait_ready(tag);
      n_i = 36'(n); d_i = 16'(d); valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      n_i = 36'($urandom); d_i = 16'($urandom);
      lat = 0;
      while (!valid_o && lat < 100) begin
         @(posedge clk_i); #1; lat++;
         if (pulse && lat == 5) valid_i = 1'b1;
         else valid_i = 1'b0;
      end
      valid_i = 1'b0;
      chk({tag, "_latency"}, lat, 37);
      chk({tag, "_q"}, longint'(q_sat_o), eq);
      chk({tag, "_r"}, longint'(r_o), er);
      chk({tag, "_sat"}, longint'(sat_o), es);
      chk({tag, "_dz"}, longint'(dz_o), ez);
      q0 = longint'(q_sat_o);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i); #1;
         chk({tag, "_hold_q"}, longint'(q_sat_o), q0);
         chk({tag, "_hold_rdy"}, longint'({ready_o, valid_o}), 1);
      end
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      chk({tag, "_release"}, longint'({ready_o, valid_o}), 2);
   endtask

   initial begin
      longint rn, rd;
      logic [63:0] raw;
      int acc0, acc1, cyc, naccept;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; n_i = '0; d_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_ready", longint'(ready_o), 1);
      chk("reset_outs", longint'({valid_o, sat_o, dz_o, q_sat_o, r_o}), 0);
      rst_i = 1'b0;

      div_check("exact",   983040, 768, 0, 0);
      div_check("rnd_pos", 256, 512, 0, 0);
      div_check("rnd_neg", -256, 512, 0, 0);
      div_check("rnd_dn",  255, 512, 0, 0);
      div_check("rnd_7_m2", 7, -2, 0, 0);
      div_check("sat_pos", 64'sd1 <<< 34, 1, 0, 0);
      div_check("neg_edge", -16777216, 512, 0, 0);
      div_check("sat_neg", -16777472, 512, 0, 0);
      div_check("sat_min", -(64'sd1 <<< 35), -1, 0, 0);
      div_check("dz_neg", -5, 0, 0, 0);
      div_check("dz_zero", 0, 0, 0, 0);
      div_check("backpress", 123456, -777, 10, 0);
      div_check("ignore_calc", -3000000, 1234, 0, 1);

      for (int k = 0; k < 16; k++) begin
         raw = {$urandom, $urandom};
         rn  = longint'($signed(raw[35:0])) >>> $urandom_range(0, 30);
         raw = 64'($urandom);
         rd  = longint'($signed(raw[15:0])) >>> $urandom_range(0, 12);
         div_check("random", rn, rd, 0, 0);
      end

      // Throughput: valid_i and ready_i both held high.
      wait_ready("tput");
      n_i = 36'sd5000; d_i = 16'sd3; valid_i = 1'b1; ready_i = 1'b1;
      acc0 = -1; acc1 = -1; naccept = 0;
      for (cyc = 0; cyc < 200 && naccept < 2; cyc++) begin
         @(negedge clk_i);
         if (ready_o) begin
            if (naccept == 0) acc0 = cyc; else acc1 = cyc;
            naccept++;
         end
      end
      chk("tput_spacing", acc1 - acc0, 39);
      valid_i = 1'b0;
      for (int t = 0; t < 100 && !ready_o; t++) @(posedge clk_i);
      @(negedge clk_i);
      ready_i = 1'b0;

      // Reset mid-CALC discards the in-flight division.
      wait_ready("rst");
      n_i = 36'sd4567; d_i = 16'sd89; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("rst_ready", longint'(ready_o), 1);
      chk("rst_outs", longint'({valid_o, sat_o, dz_o, q_sat_o, r_o}), 0);
      div_check("post_rst", 983040, 768, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/div_16q9_acc36.md
# div_16q9_acc36

Iterative signed divider that inverts the 16-bit Q9 multiply-add datapath. It takes a 36-bit Q18 accumulator value and a 16-bit Q9 divisor and returns a 16-bit Q9 quotient, rounded and saturated, plus the exact remainder. The divider sits behind the MAC stage wherever a normalisation or gain recovery (x = y / a) is needed. Valid/ready handshakes are used on both sides, and only one division is in flight at a time.

## Interface
- No parameters; all widths are fixed: N_W = 36, D_W = 16, Q_W = 16, FRAC = 9.
- clk_i  input  1  clock; every register updates on the rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- n_i  input  36  signed dividend, Q18 (product-of-Q9 scale).
- d_i  input  16  signed divisor, Q9.
- valid_i  input  1  the n_i/d_i pair is valid.
- ready_o  output  1  the divider can accept an operand pair (high only in IDLE).
- q_sat_o  output  16  signed quotient, Q9, rounded and saturated.
- r_o  output  36  signed remainder of the truncated quotient; it takes the sign of n_i.
- sat_o  output  1  q_sat_o was clamped, or the division was by zero.
- dz_o  output  1  the divisor was zero.
- valid_o  output  1  the result outputs are valid.
- ready_i  input  1  the consumer accepts the result.

## Operation
- Q18 divided by Q9 gives Q9, so q_sat_o is round(n_i / d_i) computed on raw integers.
- **Accept:** an operand pair is accepted at the edge where valid_i and ready_o are both high. At that edge the block registers:
  - sign = n[35] ^ d[15];
  - |n| as a 36-bit unsigned value (-2^35 is exact);
  - |d| as a 16-bit unsigned value;
  - a dz flag, set when d_i == 0.
- **CALC:** unsigned restoring division, 1 quotient bit per cycle, MSB first, 36 cycles.
  - Partial remainder is 17 bits, quotient register is 36 bits.
  - Produces Q = floor(|n|/|d|) and R = |n| mod |d|.
- **ROUND:**
  - Round half away from zero: Qr = Q + (2R >= |d|).
  - Signed result = sign ? -Qr : Qr.
  - Saturation limits: a positive result above 32767 becomes 32767 (0x7FFF); a negative result below -32768 becomes -32768 (0x8000). Either case sets sat_o.
  - Magnitude arithmetic in ROUND is 37 bits, so Qr never wraps.
  - r_o = n[35] ? -R : R.
- **Divide by zero:**
  - q_sat_o = 32767 if n_i >= 0, otherwise -32768.
  - r_o = n_i, sat_o = 1, dz_o = 1.
  - Latency is unchanged: the FSM still walks through CALC, and its result is overridden in ROUND.
- **FSM states and transitions:**
  - IDLE → CALC on an input handshake.
  - CALC → ROUND when the iteration counter reaches 35 (6-bit counter, 0..35).
  - ROUND → DONE unconditionally.
  - DONE → IDLE on an output handshake (valid_o & ready_i).
- Result outputs are registered and stay stable throughout DONE.

## Timing
- **Reset values:** state IDLE, ready_o = 1, valid_o = 0, q_sat_o = 0, r_o = 0, sat_o = 0, dz_o = 0, counter = 0.
- **Latency:** with the input handshake at edge E0, CALC occupies edges E1..E36 and ROUND registers the outputs at E37. valid_o is high from the cycle after E37 onward.
- ready_o is decoded from state (IDLE). It is low from the cycle after acceptance until the cycle after the output handshake.
- **Throughput:** one result per 39 cycles when ready_i is held high. There is no input/output overlap; a new operand pair cannot be accepted in the same cycle as the output handshake.
- **Backpressure:** if ready_i stays low, DONE holds indefinitely and no input is accepted.
- valid_i asserted outside IDLE is ignored; the inputs are not captured.
- rst_i in any state returns the block to IDLE at the next edge with all reset values. An in-flight result is discarded.

## Structure
- Package div_16q9_pkg holds:
  - N_W, D_W, Q_W, FRAC;
  - Q_MAX = 16'sh7FFF and Q_MIN = 16'sh8000;
  - the state enum typedef (IDLE, CALC, ROUND, DONE);
  - the counter width.
- Optional sub-module div_16q9_rnd_sat is purely combinational. It takes Q, R, |d|, sign, dz and n_i, and produces q_sat_o, r_o, sat_o and dz_o. It is instantiated once, feeding the ROUND-stage registers.
- The top module holds the FSM, the counter and the shift/subtract datapath.

## Test plan
1. **Exact quotient:** n = 983040 (3.75), d = 768 (1.5) → q_sat_o = 1280 (2.5), r_o = 0, sat_o = 0, dz_o = 0. valid_o rises 37 cycles after the accept edge.
2. **Rounding:**
   - n = 256, d = 512 → q = 1, r = 256.
   - n = -256, d = 512 → q = -1, r = -256.
   - n = 255, d = 512 → q = 0, r = 255.
   - n = 7, d = -2 → q = -4, r = 1.
3. **Saturation:**
   - n = 2^34, d = 1 → q = 32767, sat_o = 1.
   - n = -16777216, d = 512 → q = -32768, sat_o = 0.
   - n = -16777472, d = 512 → q = -32768, sat_o = 1.
   - n = -2^35, d = -1 → q = 32767, sat_o = 1.
4. **Divide by zero:**
   - n = -5, d = 0 → q = -32768, r = -5, sat_o = 1, dz_o = 1.
   - n = 0, d = 0 → q = 32767, dz_o = 1.
5. **Handshake:**
   - Hold ready_i = 0 for 10 cycles in DONE → outputs are stable and ready_o = 0.
   - valid_i pulsed during CALC → ignored; the next result matches the original operands.
   - Back-to-back operands with ready_i = 1 → accepts are 39 cycles apart.
6. **Reset:** assert rst_i at CALC cycle 20 → next cycle state is IDLE, ready_o = 1, valid_o = 0, and all outputs are 0. A subsequent division (case 1) completes correctly.
